// File: rtl/adder_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : adder_share_arbiter (plus helper adder_top)
// Purpose  : Round-robin sharing of one ripple adder between NREQ requesters,
//            with valid/ready request ports and a tagged response channel.
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// adder_top: (WIDTH+1)-bit ripple-carry adder. Operands arrive zero-extended,
// so the (WIDTH+1)-bit sum is exact and its MSB is the carry-out of A+B.
// ----------------------------------------------------------------------------
module adder_top #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0] i_a,
  input  logic [WIDTH:0] i_b,
  output logic [WIDTH:0] o_sum
);

  logic [WIDTH:0] w_carry;

  assign w_carry[0] = 1'b0;

  generate
    for (genvar gi = 0; gi <= WIDTH; gi++) begin : g_fa
      assign o_sum[gi] = i_a[gi] ^ i_b[gi] ^ w_carry[gi];
      // The carry out of the top bit is never needed (it is always zero).
      if (gi < WIDTH) begin : g_carry
        assign w_carry[gi+1] = (i_a[gi] & i_b[gi]) |
                               (w_carry[gi] & (i_a[gi] ^ i_b[gi]));
      end
    end
  endgenerate

endmodule

// ----------------------------------------------------------------------------
// adder_share_arbiter
// ----------------------------------------------------------------------------
module adder_share_arbiter #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_data_A,
  input  logic [NREQ*WIDTH-1:0]   req_data_B,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [WIDTH:0]          resp_result,
  output logic [$clog2(NREQ)-1:0] resp_id
);

  localparam int ID_W = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          r_state;
  logic [ID_W-1:0] r_rr_ptr;
  logic [ID_W-1:0] r_id;
  logic [WIDTH:0]  r_op_a;
  logic [WIDTH:0]  r_op_b;

  logic            w_can_grant;
  logic            w_any;
  logic            w_accept;
  logic [ID_W-1:0] w_grant;
  logic [ID_W-1:0] w_grant_nxt;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic [WIDTH:0]  w_sum;

  // A new request may be taken when idle, or when the held response is being
  // consumed this very cycle (keeps the 2-cycle issue rate).
  assign w_can_grant = (r_state == S_IDLE) || ((r_state == S_RESP) && resp_ready);
  assign w_accept    = w_can_grant && w_any;

  // Round-robin search: scan from r_rr_ptr upward with wrap. The scan runs
  // from the farthest offset down so the nearest valid index wins.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    w_grant = '0;
    w_any   = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = 32'(r_rr_ptr) + 32'(k);
      if (idx >= 32'(NREQ)) begin
        idx = idx - 32'(NREQ);
      end
      if (req_valid[idx]) begin
        w_grant = idx[ID_W-1:0];
        w_any   = 1'b1;
      end
    end
  end

  // One-hot ready toward the granted requester only.
  always_comb begin
    req_ready = '0;
    if (w_accept) begin
      req_ready[w_grant] = 1'b1;
    end
  end

  // Pointer advance after a grant, wrapping at NREQ (NREQ need not be 2^n).
  assign w_grant_nxt = (w_grant == ID_W'(NREQ - 1)) ? '0 : w_grant + 1'b1;

  assign w_sel_a = req_data_A[32'(w_grant)*WIDTH +: WIDTH];
  assign w_sel_b = req_data_B[32'(w_grant)*WIDTH +: WIDTH];

  adder_top #(
    .WIDTH (WIDTH)
  ) u_adder (
    .i_a   (r_op_a),
    .i_b   (r_op_b),
    .o_sum (w_sum)
  );

  // Sequencer: accept -> CALC (operands registered) -> RESP (result held).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_id        <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      resp_valid  <= 1'b0;
      resp_result <= '0;
      resp_id     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op_a   <= {1'b0, w_sel_a};
            r_op_b   <= {1'b0, w_sel_b};
            r_id     <= w_grant;
            r_rr_ptr <= w_grant_nxt;
            r_state  <= S_CALC;
          end
        end
        S_CALC: begin
          resp_result <= w_sum;
          resp_id     <= r_id;
          resp_valid  <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            if (w_accept) begin
              r_op_a   <= {1'b0, w_sel_a};
              r_op_b   <= {1'b0, w_sel_b};
              r_id     <= w_grant;
              r_rr_ptr <= w_grant_nxt;
              r_state  <= S_CALC;
            end else begin
              r_state  <= S_IDLE;
            end
          end
        end
        default: begin
          r_state    <= S_IDLE;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_adder_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_share_arbiter
// Purpose  : Scoreboard bench for adder_share_arbiter: per-requester stimulus
//            queues, expected responses queued at issue, negedge monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_share_arbiter;

  localparam int W    = 16;
  localparam int NREQ = 4;
  localparam int ID_W = 2;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [W:0]      res;
  } exp_t;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*W-1:0]     req_data_A;
  logic [NREQ*W-1:0]     req_data_B;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [W:0]            resp_result;
  logic [ID_W-1:0]       resp_id;

  logic [2*W-1:0]        pend [NREQ][$];
  exp_t                  exp_q [$];
  logic [NREQ-1:0]       hs_s;
  int                    checks;
  int                    errors;
  int                    nresp;

  adder_share_arbiter #(
    .WIDTH (W),
    .NREQ  (NREQ)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_data_A  (req_data_A),
    .req_data_B  (req_data_B),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_id     (resp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake sample, taken where inputs are stable up to the next edge.
  always @(negedge clk) hs_s = req_valid & req_ready & {NREQ{rst_n}};

  // Requester driver: pop accepted items, present the head of each queue.
  initial begin
    req_valid  = '0;
    req_data_A = '0;
    req_data_B = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (hs_s[i] && pend[i].size() > 0) void'(pend[i].pop_front());
      end
      for (int i = 0; i < NREQ; i++) begin
        if (pend[i].size() > 0) begin
          req_valid[i]          = 1'b1;
          req_data_A[i*W +: W]  = pend[i][0][2*W-1:W];
          req_data_B[i*W +: W]  = pend[i][0][W-1:0];
        end else begin
          req_valid[i]          = 1'b0;
        end
      end
    end
  end

  // Monitor: every consumed response is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ((req_ready & (req_ready - 1'b1)) != '0) begin
        errors++;
        $display("FAIL ready_onehot: req_ready=%b, required at most one bit", req_ready);
      end
      if (resp_valid && resp_ready) begin
        exp_t e;
        checks++;
        nresp++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL resp_unexpected: got id=%0d res=0x%05h, required no response", resp_id, resp_result);
        end else begin
          e = exp_q.pop_front();
          if (resp_id !== e.id || resp_result !== e.res) begin
            errors++;
            $display("FAIL resp#%0d: got id=%0d res=0x%05h, required id=%0d res=0x%05h",
                     nresp, resp_id, resp_result, e.id, e.res);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, want);
    end
  endtask

  task automatic issue(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W:0] res, input bit expect_resp);
    exp_t e;
    pend[id].push_back({a, b});
    if (expect_resp) begin
      e.id  = ID_W'(id);
      e.res = res;
      exp_q.push_back(e);
    end
  endtask

  function automatic int pending_total();
    int n = 0;
    for (int i = 0; i < NREQ; i++) n += pend[i].size();
    return n;
  endfunction

  task automatic wait_drain(input string name, input int max_cyc);
    int n = 0;
    while ((pending_total() > 0 || exp_q.size() > 0) && n < max_cyc) begin
      @(posedge clk); #2; n++;
    end
    checks++;
    if (pending_total() > 0 || exp_q.size() > 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d requests / %0d responses outstanding, required 0",
               name, pending_total(), exp_q.size());
    end
  endtask

  task automatic wait_accept(input string name, input int id, input int max_cyc);
    int n = 0;
    while (pend[id].size() > 0 && n < max_cyc) begin
      @(posedge clk); #2; n++;
    end
    checks++;
    if (pend[id].size() > 0) begin
      errors++;
      $display("FAIL %s_timeout: req %0d never accepted", name, id);
    end
  endtask

  initial begin
    logic [W:0]      held_res;
    logic [ID_W-1:0] held_id;
    int              n;
    checks     = 0;
    errors     = 0;
    nresp      = 0;
    rst_n      = 1'b0;
    resp_ready = 1'b1;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    chk("rst_resp_valid",  32'(resp_valid),  32'h0);
    chk("rst_resp_result", 32'(resp_result), 32'h0);
    chk("rst_resp_id",     32'(resp_id),     32'h0);
    chk("rst_req_ready",   32'(req_ready),   32'h0);
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_no_valid", 32'(resp_valid), 32'h0);

    // ---- single request with latency check ----
    @(posedge clk); #2;
    issue(2, 16'h0003, 16'h0004, 17'h00007, 1'b1);
    wait_accept("single", 2, 20);
    @(negedge clk);
    chk("single_calc_valid", 32'(resp_valid), 32'h0);
    chk("single_calc_ready", 32'(req_ready),  32'h0);
    @(negedge clk);
    chk("single_resp_valid", 32'(resp_valid), 32'h1);
    wait_drain("single", 20);

    // ---- carry and maximum ----
    issue(1, 16'hFFFF, 16'h0001, 17'h10000, 1'b1);
    issue(1, 16'hFFFF, 16'hFFFF, 17'h1FFFE, 1'b1);
    wait_drain("carry", 30);

    // ---- fairness from reset: all four valid ----
    rst_n = 1'b0;
    issue(0, 16'h0010, 16'h0001, 17'h00011, 1'b1);
    issue(1, 16'h0100, 16'h0020, 17'h00120, 1'b1);
    issue(2, 16'h1000, 16'h0300, 17'h01300, 1'b1);
    issue(3, 16'h8000, 16'h8000, 17'h10000, 1'b1);
    issue(0, 16'h1234, 16'h4321, 17'h05555, 1'b1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    wait_drain("fair4", 40);

    // ---- fairness between req 0 and 3 (pointer at 1) ----
    issue(3, 16'h0001, 16'h0002, 17'h00003, 1'b1);
    issue(0, 16'h00FF, 16'h0001, 17'h00100, 1'b1);
    issue(3, 16'h7FFF, 16'h0001, 17'h08000, 1'b1);
    wait_drain("fair03", 30);

    // ---- backpressure ----
    resp_ready = 1'b0;
    issue(1, 16'h0005, 16'h000A, 17'h0000F, 1'b1);
    issue(2, 16'h2222, 16'h1111, 17'h03333, 1'b1);
    n = 0;
    do begin @(negedge clk); n++; end while (!resp_valid && n < 20);
    chk("bp_resp_valid", 32'(resp_valid), 32'h1);
    held_res = resp_result;
    held_id  = resp_id;
    chk("bp_first_id", 32'(held_id), 32'h1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_hold_result", 32'(resp_result), 32'(held_res));
      chk("bp_hold_id",     32'(resp_id),     32'(held_id));
      chk("bp_req_ready",   32'(req_ready),   32'h0);
    end
    @(posedge clk); #2 resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(req_ready),  32'h4);
    chk("b2b_valid_1",      32'(resp_valid), 32'h1);
    @(negedge clk);
    chk("b2b_valid_0",      32'(resp_valid), 32'h0);
    @(negedge clk);
    chk("b2b_valid_1b",     32'(resp_valid), 32'h1);
    chk("b2b_id",           32'(resp_id),    32'h2);
    wait_drain("bp", 20);

    // ---- reset during CALC ----
    issue(1, 16'h0AAA, 16'h0555, 17'h00FFF, 1'b0);
    wait_accept("rstcalc", 1, 20);
    rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) pend[i].delete();
    #1 chk("rst_mid_valid", 32'(resp_valid), 32'h0);
    repeat (3) @(negedge clk);
    chk("rst_mid_valid_hold", 32'(resp_valid), 32'h0);
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_no_stale", 32'(resp_valid), 32'h0);
    end
    @(posedge clk); #2;
    issue(3, 16'h0004, 16'h0004, 17'h00008, 1'b0);
    issue(1, 16'h0002, 16'h0003, 17'h00005, 1'b1);
    exp_q.push_back('{id: 2'd3, res: 17'h00008});
    wait_drain("post_rst", 30);

    repeat (3) @(negedge clk);
    chk("final_exp_empty", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global guard so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
